// File: rtl/deco.sv
// deco: registered field decoder for ARM-style 32-bit instruction words
module deco (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instruccion,
    output logic        out_valid,
    output logic [3:0]  Cond,
    output logic [1:0]  Op,
    output logic        I,
    output logic        Uno,
    output logic        P,
    output logic        U,
    output logic        B,
    output logic        W,
    output logic        S,
    output logic        L1,
    output logic        L2,
    output logic [3:0]  OpCode,
    output logic [3:0]  Rn,
    output logic [3:0]  Rd,
    output logic [11:0] Operand2,
    output logic [11:0] OffsetSTD,
    output logic [23:0] OffsetBranch
);
    typedef enum logic [1:0] {
        DP  = 2'b00,
        SDT = 2'b01,
        BR  = 2'b10,
        UND = 2'b11
    } op_class_t;

    op_class_t   cls;
    logic        is_dp, is_sdt, is_br, is_mem;
    logic        n_i, n_uno, n_p, n_u, n_b, n_w, n_s, n_l1, n_l2;
    logic [3:0]  n_opcode, n_rn, n_rd;
    logic [11:0] n_operand2, n_offset_std;
    logic [23:0] n_offset_branch;

    assign cls    = op_class_t'(instruccion[27:26]);
    assign is_dp  = cls == DP;
    assign is_sdt = cls == SDT;
    assign is_br  = cls == BR;
    assign is_mem = is_dp || is_sdt;

    // next-value decode: each field passes only for the classes that own it, else 0
    always_comb begin
        n_i             = is_mem ? instruccion[25] : 1'b0;
        n_uno           = is_br  ? instruccion[25] : 1'b0;
        n_p             = is_sdt ? instruccion[24] : 1'b0;
        n_u             = is_sdt ? instruccion[23] : 1'b0;
        n_b             = is_sdt ? instruccion[22] : 1'b0;
        n_w             = is_sdt ? instruccion[21] : 1'b0;
        n_s             = is_dp  ? instruccion[20] : 1'b0;
        n_l1            = is_sdt ? instruccion[20] : 1'b0;
        n_l2            = is_br  ? instruccion[24] : 1'b0;
        n_opcode        = is_dp  ? instruccion[24:21] : 4'd0;
        n_rn            = is_mem ? instruccion[19:16] : 4'd0;
        n_rd            = is_mem ? instruccion[15:12] : 4'd0;
        n_operand2      = is_dp  ? instruccion[11:0] : 12'd0;
        n_offset_std    = is_sdt ? instruccion[11:0] : 12'd0;
        n_offset_branch = is_br  ? instruccion[23:0] : 24'd0;
    end

    // output registers: reset clears everything, a valid word loads, otherwise fields hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            Cond         <= 4'd0;
            Op           <= 2'd0;
            I            <= 1'b0;
            Uno          <= 1'b0;
            P            <= 1'b0;
            U            <= 1'b0;
            B            <= 1'b0;
            W            <= 1'b0;
            S            <= 1'b0;
            L1           <= 1'b0;
            L2           <= 1'b0;
            OpCode       <= 4'd0;
            Rn           <= 4'd0;
            Rd           <= 4'd0;
            Operand2     <= 12'd0;
            OffsetSTD    <= 12'd0;
            OffsetBranch <= 24'd0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Cond         <= instruccion[31:28];
                Op           <= instruccion[27:26];
                I            <= n_i;
                Uno          <= n_uno;
                P            <= n_p;
                U            <= n_u;
                B            <= n_b;
                W            <= n_w;
                S            <= n_s;
                L1           <= n_l1;
                L2           <= n_l2;
                OpCode       <= n_opcode;
                Rn           <= n_rn;
                Rd           <= n_rd;
                Operand2     <= n_operand2;
                OffsetSTD    <= n_offset_std;
                OffsetBranch <= n_offset_branch;
            end
        end
    end
endmodule

// File: tb/tb_deco.sv
// tb_deco: directed and randomized checks of deco against a field-level reference model
module tb_deco;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instruccion = 32'd0;
    logic        out_valid;
    logic [3:0]  Cond;
    logic [1:0]  Op;
    logic        I, Uno, P, U, B, W, S, L1, L2;
    logic [3:0]  OpCode, Rn, Rd;
    logic [11:0] Operand2, OffsetSTD;
    logic [23:0] OffsetBranch;

    int total = 0;
    int bad = 0;
    logic [75:0] exp_v = '0;
    logic [75:0] obs;

    deco dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruccion(instruccion),
        .out_valid(out_valid), .Cond(Cond), .Op(Op), .I(I), .Uno(Uno),
        .P(P), .U(U), .B(B), .W(W), .S(S), .L1(L1), .L2(L2),
        .OpCode(OpCode), .Rn(Rn), .Rd(Rd), .Operand2(Operand2),
        .OffsetSTD(OffsetSTD), .OffsetBranch(OffsetBranch)
    );

    always #5 clk = ~clk;

    assign obs = {out_valid, Cond, Op, I, Uno, P, U, B, W, S, L1, L2,
                  OpCode, Rn, Rd, Operand2, OffsetSTD, OffsetBranch};

    // Reference: pick fields by class with shifts and masks on the raw word
    function automatic logic [75:0] model(input logic [31:0] w);
        int unsigned cls = (w >> 26) & 3;
        logic dp  = (cls == 0);
        logic sdt = (cls == 1);
        logic br  = (cls == 2);
        logic [3:0]  cond  = 4'((w >> 28) & 15);
        logic [1:0]  op    = 2'(cls);
        logic        b25   = 1'((w >> 25) & 1);
        logic        b24   = 1'((w >> 24) & 1);
        logic        b23   = 1'((w >> 23) & 1);
        logic        b22   = 1'((w >> 22) & 1);
        logic        b21   = 1'((w >> 21) & 1);
        logic        b20   = 1'((w >> 20) & 1);
        logic [3:0]  opc   = 4'((w >> 21) & 15);
        logic [3:0]  rn    = 4'((w >> 16) & 15);
        logic [3:0]  rd    = 4'((w >> 12) & 15);
        logic [11:0] low12 = 12'(w % 4096);
        logic [23:0] low24 = 24'(w % 32'h0100_0000);
        return {1'b1, cond, op,
                (dp | sdt) & b25, br & b25, sdt & b24, sdt & b23, sdt & b22, sdt & b21,
                dp & b20, sdt & b20, br & b24,
                dp ? opc : 4'd0, (dp | sdt) ? rn : 4'd0, (dp | sdt) ? rd : 4'd0,
                dp ? low12 : 12'd0, sdt ? low12 : 12'd0, br ? low24 : 24'd0};
    endfunction

    task automatic step(input logic r, input logic v, input logic [31:0] w);
        rst = r;
        in_valid = v;
        instruccion = w;
        @(posedge clk);
        #1;
        if (r) exp_v = '0;
        else if (v) exp_v = model(w);
        else exp_v[75] = 1'b0;
    endtask

    task automatic check(input string tag, input logic [75:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    localparam logic [75:0] DP_EXP  = {1'b1, 4'b1000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                       1'b1, 1'b0, 1'b0, 4'b1000, 4'h8, 4'h8, 12'hFFF, 12'h0, 24'h0};
    localparam logic [75:0] SDT_EXP = {1'b1, 4'b1000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                       1'b0, 1'b1, 1'b0, 4'h0, 4'h8, 4'h8, 12'h0, 12'hE1F, 24'h0};
    localparam logic [75:0] BR_EXP  = {1'b1, 4'b1000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                       1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 12'h0, 12'h0, 24'hF88E1F};
    localparam logic [75:0] UND_EXP = {1'b1, 4'b1110, 2'b11, 69'd0};

    initial begin
        logic [31:0] w;
        step(1'b1, 1'b0, 32'd0);
        check("reset_state", 76'd0);
        step(1'b0, 1'b1, 32'h8318_8FFF);
        check("dp_fields", DP_EXP);
        check("dp_model", exp_v);
        step(1'b0, 1'b0, 32'hFFFF_FFFF);
        check("hold_after_dp", {1'b0, DP_EXP[74:0]});
        step(1'b0, 1'b1, 32'h84F8_8E1F);
        check("sdt_fields", SDT_EXP);
        step(1'b0, 1'b1, 32'h8AF8_8E1F);
        check("br_fields", BR_EXP);
        step(1'b0, 1'b1, 32'hEC00_0000);
        check("und_fields", UND_EXP);
        step(1'b1, 1'b1, 32'h8AF8_8E1F);
        check("reset_drops_br", 76'd0);
        step(1'b0, 1'b1, 32'h8318_8FFF);
        check("dp_after_reset", DP_EXP);
        step(1'b0, 1'b1, 32'h84F8_8E1F);
        check("back_to_back_sdt", SDT_EXP);
        for (int k = 0; k < 300; k++) begin
            w = $urandom;
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), w);
            check("random", exp_v);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
